exu_swc_sequencer: RTL and testbench

- Sequences the software-controlled execution units (ALU, jump, LSU slices) that each consume a shared `cycle_cnt` step index.
- Accepts one decoded instruction at a time and enables the selected unit. Drives `cycle_cnt` from 0 up to the instruction's last step, honouring unit stalls.
- Owns the single register-file read/write port and the PC-write/flush path, muxing them from the active unit only.
- Sits between the decoder and the `exu_*_swc` units.

---
 rtl/exu_swc_pkg.sv | 9 +
 rtl/exu_swc_port_mux.sv | 49 ++++
 rtl/exu_swc_sequencer.sv | 130 +++++++++++++
 tb/tb_exu_swc_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/exu_swc_pkg.sv
// exu_swc_pkg: shared unit indices, widths and FSM state for the software-controlled execution sequencer.
package exu_swc_pkg;
  localparam int UNIT_ALU = 0;
  localparam int UNIT_JMP = 1;
  localparam int UNIT_LSU = 2;
  localparam int SWC_CNT_W = 4;
  localparam int STALL_W = 8;
  typedef enum logic {IDLE, EXEC} swc_state_e;
endpackage

// File: rtl/exu_swc_port_mux.sv
// exu_swc_port_mux: one-hot select mux of per-unit register-file and PC ports; zero select yields all-zero outputs.
module exu_swc_port_mux #(
  parameter int NUM_UNITS = 3,
  parameter int XLEN = 32
) (
  input  logic [NUM_UNITS-1:0]      sel_i,
  input  logic [NUM_UNITS-1:0]      u_reg_wen_i,
  input  logic [5*NUM_UNITS-1:0]    u_reg_waddr_i,
  input  logic [XLEN*NUM_UNITS-1:0] u_reg_wdata_i,
  input  logic [NUM_UNITS-1:0]      u_reg_ren_1_i,
  input  logic [5*NUM_UNITS-1:0]    u_reg_raddr_1_i,
  input  logic [NUM_UNITS-1:0]      u_pc_write_i,
  input  logic [XLEN*NUM_UNITS-1:0] u_pc_wdata_i,
  input  logic [2*NUM_UNITS-1:0]    u_flush_i,
  output logic                      reg_wen_o,
  output logic [4:0]                reg_waddr_o,
  output logic [XLEN-1:0]           reg_wdata_o,
  output logic                      reg_ren_1_o,
  output logic [4:0]                reg_raddr_1_o,
  output logic                      pc_write_o,
  output logic [XLEN-1:0]           pc_wdata_o,
  output logic [1:0]                flush_o
);
  logic wen;
  always_comb begin
    wen = 1'b0;
    reg_waddr_o = '0;
    reg_wdata_o = '0;
    reg_ren_1_o = 1'b0;
    reg_raddr_1_o = '0;
    pc_write_o = 1'b0;
    pc_wdata_o = '0;
    flush_o = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel_i[i]) begin
        wen = u_reg_wen_i[i];
        reg_waddr_o = u_reg_waddr_i[5*i +: 5];
        reg_wdata_o = u_reg_wdata_i[XLEN*i +: XLEN];
        reg_ren_1_o = u_reg_ren_1_i[i];
        reg_raddr_1_o = u_reg_raddr_1_i[5*i +: 5];
        pc_write_o = u_pc_write_i[i];
        pc_wdata_o = u_pc_wdata_i[XLEN*i +: XLEN];
        flush_o = u_flush_i[2*i +: 2];
      end
    end
  end
  // x0 is hardwired zero, so writes to it never reach the register file
  assign reg_wen_o = wen & (|reg_waddr_o);
endmodule

// File: rtl/exu_swc_sequencer.sv
// exu_swc_sequencer: issues one decoded instruction at a time to an execution unit, steps cycle_cnt with stall handling,
// and owns the shared register-file and PC ports.
module exu_swc_sequencer
  import exu_swc_pkg::*;
#(
  parameter int NUM_UNITS = 3,
  parameter int CNT_W = SWC_CNT_W,
  parameter int XLEN = 32,
  parameter int STALL_MAX = 255
) (
  input  logic                      hclk,
  input  logic                      hrstn,
  input  logic                      dec_valid,
  output logic                      dec_ready,
  input  logic [NUM_UNITS-1:0]      dec_unit_sel,
  input  logic [CNT_W-1:0]          dec_cycles,
  output logic [NUM_UNITS-1:0]      unit_en,
  output logic [CNT_W-1:0]          cycle_cnt,
  input  logic [NUM_UNITS-1:0]      unit_stall,
  output logic                      instr_done,
  output logic                      sel_err,
  output logic                      timeout_err,
  output logic                      wr_conflict,
  input  logic [NUM_UNITS-1:0]      u_reg_wen,
  input  logic [5*NUM_UNITS-1:0]    u_reg_waddr,
  input  logic [XLEN*NUM_UNITS-1:0] u_reg_wdata,
  input  logic [NUM_UNITS-1:0]      u_reg_ren_1,
  input  logic [5*NUM_UNITS-1:0]    u_reg_raddr_1,
  input  logic [NUM_UNITS-1:0]      u_pc_write,
  input  logic [XLEN*NUM_UNITS-1:0] u_pc_wdata,
  input  logic [2*NUM_UNITS-1:0]    u_flush,
  output logic                      reg_wen,
  output logic [4:0]                reg_waddr,
  output logic [XLEN-1:0]           reg_wdata,
  output logic                      reg_ren_1,
  output logic [4:0]                reg_raddr_1,
  output logic                      pc_write,
  output logic [XLEN-1:0]           pc_wdata,
  output logic [1:0]                flush
);
  swc_state_e state_q, state_d;
  logic [NUM_UNITS-1:0] sel_q, sel_d, active;
  logic [CNT_W-1:0] last_q, last_d, cnt_q, cnt_d, dec_last;
  logic [STALL_W-1:0] stall_q, stall_d, stall_inc;
  logic done_q, sel_err_q, tmo_q, wrc_q;
  logic exec, onehot, stalled, fin, abort, accept;
  assign exec = state_q == EXEC;
  assign active = exec ? sel_q : '0;
  assign onehot = (dec_unit_sel != '0) && ((dec_unit_sel & (dec_unit_sel - 1'b1)) == '0);
  assign dec_last = (dec_cycles == '0) ? '0 : dec_cycles - 1'b1;
  assign stalled = |(unit_stall & active);
  assign stall_inc = stall_q + 1'b1;
  assign fin = exec && (cnt_q == last_q) && !stalled;
  assign abort = stalled && (stall_inc == STALL_W'(STALL_MAX));
  assign dec_ready = !exec || fin;
  assign accept = dec_ready && dec_valid && onehot;
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    cnt_d = cnt_q;
    stall_d = stall_q;
    if (abort || (fin && !accept) || !exec) begin
      state_d = IDLE;
      cnt_d = '0;
      stall_d = '0;
    end else if (stalled) begin
      stall_d = stall_inc;
    end else begin
      stall_d = '0;
      cnt_d = cnt_q + 1'b1;
    end
    // retirement and acceptance may coincide: the next instruction starts at step 0 without a bubble
    if (accept) begin
      state_d = EXEC;
      sel_d = dec_unit_sel;
      last_d = dec_last;
      cnt_d = '0;
      stall_d = '0;
    end
  end
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q <= IDLE;
      sel_q <= '0;
      last_q <= '0;
      cnt_q <= '0;
      stall_q <= '0;
      done_q <= 1'b0;
      sel_err_q <= 1'b0;
      tmo_q <= 1'b0;
      wrc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      stall_q <= stall_d;
      done_q <= fin || abort;
      sel_err_q <= dec_ready && dec_valid && !onehot;
      tmo_q <= abort;
      wrc_q <= |(u_reg_wen & ~active);
    end
  end
  assign unit_en = active;
  assign cycle_cnt = cnt_q;
  assign instr_done = done_q;
  assign sel_err = sel_err_q;
  assign timeout_err = tmo_q;
  assign wr_conflict = wrc_q;
  exu_swc_port_mux #(.NUM_UNITS(NUM_UNITS), .XLEN(XLEN)) u_mux (
    .sel_i(active),
    .u_reg_wen_i(u_reg_wen),
    .u_reg_waddr_i(u_reg_waddr),
    .u_reg_wdata_i(u_reg_wdata),
    .u_reg_ren_1_i(u_reg_ren_1),
    .u_reg_raddr_1_i(u_reg_raddr_1),
    .u_pc_write_i(u_pc_write),
    .u_pc_wdata_i(u_pc_wdata),
    .u_flush_i(u_flush),
    .reg_wen_o(reg_wen),
    .reg_waddr_o(reg_waddr),
    .reg_wdata_o(reg_wdata),
    .reg_ren_1_o(reg_ren_1),
    .reg_raddr_1_o(reg_raddr_1),
    .pc_write_o(pc_write),
    .pc_wdata_o(pc_wdata),
    .flush_o(flush)
  );
endmodule

// File: tb/tb_exu_swc_sequencer.sv
// tb_exu_swc_sequencer: directed and randomized stimulus checked cycle by cycle against an instruction-level model.
module tb_exu_swc_sequencer;
  localparam int N = 3;
  localparam int CW = 4;
  localparam int XL = 32;
  localparam int SMAX = 6;
  logic hclk = 1'b0, hrstn = 1'b0;
  logic dec_valid = 1'b0, dec_ready;
  logic [N-1:0] dec_unit_sel = '0, unit_en, unit_stall = '0;
  logic [CW-1:0] dec_cycles = '0, cycle_cnt;
  logic instr_done, sel_err, timeout_err, wr_conflict;
  logic [N-1:0] u_reg_wen = '0, u_reg_ren_1 = '0, u_pc_write = '0;
  logic [5*N-1:0] u_reg_waddr = '0, u_reg_raddr_1 = '0;
  logic [XL*N-1:0] u_reg_wdata = '0, u_pc_wdata = '0;
  logic [2*N-1:0] u_flush = '0;
  logic reg_wen, reg_ren_1, pc_write;
  logic [4:0] reg_waddr, reg_raddr_1;
  logic [XL-1:0] reg_wdata, pc_wdata;
  logic [1:0] flush;
  int n_chk = 0, n_ok = 0;
  bit m_busy = 0;
  int m_u = 0, m_last = 0, m_step = 0, m_stall = 0;
  bit p_done = 0, p_sel = 0, p_tmo = 0, p_wrc = 0;
  int burst = 0;

  exu_swc_sequencer #(.NUM_UNITS(N), .CNT_W(CW), .XLEN(XL), .STALL_MAX(SMAX)) dut (
    .hclk(hclk), .hrstn(hrstn), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_unit_sel(dec_unit_sel), .dec_cycles(dec_cycles), .unit_en(unit_en), .cycle_cnt(cycle_cnt),
    .unit_stall(unit_stall), .instr_done(instr_done), .sel_err(sel_err), .timeout_err(timeout_err),
    .wr_conflict(wr_conflict), .u_reg_wen(u_reg_wen), .u_reg_waddr(u_reg_waddr), .u_reg_wdata(u_reg_wdata),
    .u_reg_ren_1(u_reg_ren_1), .u_reg_raddr_1(u_reg_raddr_1), .u_pc_write(u_pc_write),
    .u_pc_wdata(u_pc_wdata), .u_flush(u_flush), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .reg_ren_1(reg_ren_1), .reg_raddr_1(reg_raddr_1), .pc_write(pc_write),
    .pc_wdata(pc_wdata), .flush(flush)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_step = 0; m_stall = 0;
    p_done = 0; p_sel = 0; p_tmo = 0; p_wrc = 0;
  endtask

  task automatic step();
    bit stl, fin, abort, ready, onehot;
    logic [N-1:0] act;
    #1;
    act = m_busy ? N'(1 << m_u) : '0;
    stl = m_busy && unit_stall[m_u];
    fin = m_busy && m_step == m_last && !stl;
    ready = !m_busy || fin;
    chk("dec_ready", dec_ready, ready);
    chk("unit_en", unit_en, act);
    chk("cycle_cnt", cycle_cnt, m_busy ? m_step : 0);
    chk("instr_done", instr_done, p_done);
    chk("sel_err", sel_err, p_sel);
    chk("timeout_err", timeout_err, p_tmo);
    chk("wr_conflict", wr_conflict, p_wrc);
    chk("reg_wen", reg_wen, m_busy && u_reg_wen[m_u] && u_reg_waddr[5*m_u +: 5] != 0);
    chk("reg_waddr", reg_waddr, m_busy ? u_reg_waddr[5*m_u +: 5] : 0);
    chk("reg_wdata", reg_wdata, m_busy ? u_reg_wdata[XL*m_u +: XL] : 0);
    chk("reg_ren_1", reg_ren_1, m_busy && u_reg_ren_1[m_u]);
    chk("reg_raddr_1", reg_raddr_1, m_busy ? u_reg_raddr_1[5*m_u +: 5] : 0);
    chk("pc_write", pc_write, m_busy && u_pc_write[m_u]);
    chk("pc_wdata", pc_wdata, m_busy ? u_pc_wdata[XL*m_u +: XL] : 0);
    chk("flush", flush, m_busy ? u_flush[2*m_u +: 2] : 0);
    onehot = $countones(dec_unit_sel) == 1;
    abort = stl && m_stall + 1 == SMAX;
    p_done = fin || abort;
    p_tmo = abort;
    p_sel = ready && dec_valid && !onehot;
    p_wrc = (u_reg_wen & ~act) != 0;
    if (abort) begin m_busy = 0; m_step = 0; m_stall = 0; end
    else if (stl) m_stall++;
    else if (m_busy) begin
      m_stall = 0;
      if (fin) begin m_busy = 0; m_step = 0; end
      else m_step++;
    end
    if (ready && dec_valid && onehot) begin
      m_busy = 1; m_step = 0; m_stall = 0;
      m_last = dec_cycles == 0 ? 0 : dec_cycles - 1;
      for (int k = 0; k < N; k++) if (dec_unit_sel[k]) m_u = k;
    end
    @(negedge hclk);
  endtask

  task automatic issue(input logic [N-1:0] s, input int c);
    dec_valid = 1; dec_unit_sel = s; dec_cycles = CW'(c);
    step();
    dec_valid = 0;
  endtask

  initial begin
    bit did_rst = 0;
    repeat (2) @(negedge hclk);
    #1;
    chk("rst_unit_en", unit_en, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_ready", dec_ready, 1);
    @(negedge hclk);
    hrstn = 1;
    u_pc_wdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    u_pc_write = 3'b010; u_flush = 6'b00_10_00;
    issue(3'b010, 3);
    repeat (4) step();
    issue(3'b100, 2);
    step();
    unit_stall = 3'b100;
    repeat (4) step();
    unit_stall = 3'b000;
    repeat (3) step();
    dec_valid = 1; dec_unit_sel = 3'b001; dec_cycles = 2;
    repeat (5) step();
    issue(3'b011, 2);
    step();
    u_reg_wen = 3'b010; u_reg_waddr = {5'd3, 5'd7, 5'd9};
    issue(3'b001, 3);
    step();
    u_reg_wen = 3'b001; u_reg_waddr = {5'd3, 5'd7, 5'd0};
    repeat (3) step();
    u_reg_wen = '0;
    issue(3'b100, 5);
    unit_stall = 3'b111;
    repeat (SMAX + 2) step();
    unit_stall = '0;
    for (int i = 0; i < 5000; i++) begin
      if (!did_rst && i >= 2500 && m_busy) begin
        did_rst = 1;
        hrstn = 0;
        #1;
        chk("mid_rst_unit_en", unit_en, 0);
        chk("mid_rst_cycle_cnt", cycle_cnt, 0);
        chk("mid_rst_done", instr_done, 0);
        chk("mid_rst_reg_wen", reg_wen, 0);
        chk("mid_rst_pc_write", pc_write, 0);
        model_reset();
        @(negedge hclk);
        hrstn = 1;
      end
      dec_valid = $urandom_range(1) == 1;
      dec_unit_sel = ($urandom_range(7) == 0) ? N'($urandom) : N'(1 << $urandom_range(N - 1));
      dec_cycles = ($urandom_range(3) == 0) ? CW'($urandom) : CW'($urandom_range(3));
      if (burst == 0 && $urandom_range(40) == 0) burst = $urandom_range(SMAX + 2, 2);
      unit_stall = burst > 0 ? N'($urandom | 32'h7) : (($urandom_range(3) == 0) ? N'($urandom) : '0);
      if (burst > 0) burst--;
      u_reg_wen = N'($urandom);
      u_reg_waddr = {$urandom_range(3) == 0 ? 5'd0 : 5'($urandom), 5'($urandom), $urandom_range(3) == 0 ? 5'd0 : 5'($urandom)};
      u_reg_wdata = {$urandom, $urandom, $urandom};
      u_reg_ren_1 = N'($urandom);
      u_reg_raddr_1 = 15'($urandom);
      u_pc_write = N'($urandom);
      u_pc_wdata = {$urandom, $urandom, $urandom};
      u_flush = 6'($urandom);
      step();
    end
    if (!did_rst) chk("mid_rst_reached", 0, 1);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
